// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit/decimal-point inputs and cathode/anode outputs of the scan driver
interface seg7_scan_driver_if;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic [3:0] dp_en;
    logic [7:0] seg_cat;
    logic [3:0] seg_an;

    modport master (
        output digit1, digit2, digit3, digit4, dp_en,
        input  seg_cat, seg_an
    );

    modport slave (
        input  digit1, digit2, digit3, digit4, dp_en,
        output seg_cat, seg_an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode seven-segment scan driver with per-frame digit snapshot and
// anode-off dead time at the start of every slot; optional leading-zero blanking under SSD_LZ_BLANK_EN
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic clk,
    input logic rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        cat_q, cat_d;
    logic [3:0]        lz;
    logic              slot_tick;
    logic              blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Prescaler, slot index, frame snapshot and next registered pin values from the current slot state
    always_comb begin
        slot_tick = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d     = slot_tick ? '0 : cnt_q + 1'b1;
        idx_d     = slot_tick ? idx_q + 2'd1 : idx_q;
        snap_d    = (slot_tick && idx_q == 2'd3) ? {bus.digit4, bus.digit3, bus.digit2, bus.digit1} : snap_q;
`ifdef SSD_LZ_BLANK_EN
        lz[3]     = snap_q[3] == 4'd0;
        lz[2]     = snap_q[3] == 4'd0 && snap_q[2] == 4'd0;
        lz[1]     = snap_q[3] == 4'd0 && snap_q[2] == 4'd0 && snap_q[1] == 4'd0;
        lz[0]     = 1'b0;
`else
        lz        = 4'd0;
`endif
        blank     = (32'(cnt_q) < 32'(BLANK_CYCLES)) || lz[idx_q];
        an_d      = blank ? 4'hF : ~(4'b1 << idx_q);
        cat_d     = blank ? 8'hFF : {~bus.dp_en[idx_q], decode(snap_q[idx_q])};
    end

    // State and output registers; reset blanks the display and restarts the scan at slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            snap_q <= '0;
            an_q   <= 4'hF;
            cat_q  <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            cat_q  <= cat_d;
        end
    end

    assign bus.seg_an  = an_q;
    assign bus.seg_cat = cat_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed frame-by-frame check of the scan driver at REFRESH_DIV=8, BLANK_CYCLES=2
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   fr = 0;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cathode codes as tabulated for the display, dp bit high
    function automatic logic [7:0] cat_tab(input logic [3:0] d);
        case (d)
            4'd0:    cat_tab = 8'hC0;
            4'd1:    cat_tab = 8'hF9;
            4'd2:    cat_tab = 8'hA4;
            4'd3:    cat_tab = 8'hB0;
            4'd4:    cat_tab = 8'h99;
            4'd5:    cat_tab = 8'h92;
            4'd6:    cat_tab = 8'h82;
            4'd7:    cat_tab = 8'hF8;
            4'd8:    cat_tab = 8'h80;
            4'd9:    cat_tab = 8'h90;
            default: cat_tab = 8'hBF;
        endcase
    endfunction

    task automatic set_d(input logic [15:0] d);
        {bus.digit4, bus.digit3, bus.digit2, bus.digit1} = d;
    endtask

    // Steps n edges of a frame whose snapshot is e={d4,d3,d2,d1}; optionally changes digit1 before edge chg_c
    task automatic run_frame(input logic [15:0] e, input int n, input int chg_c, input logic [3:0] nd1);
        logic [3:0] lzb;
        logic [3:0] exp_an;
        logic [7:0] exp_cat;
        logic       bl;
        int         s;
        int         ph;
`ifdef SSD_LZ_BLANK_EN
        lzb[3] = e[15:12] == 4'd0;
        lzb[2] = lzb[3] && e[11:8] == 4'd0;
        lzb[1] = lzb[2] && e[7:4] == 4'd0;
        lzb[0] = 1'b0;
`else
        lzb = 4'd0;
`endif
        for (int c = 0; c < n; c++) begin
            if (c == chg_c) bus.digit1 = nd1;
            @(posedge clk);
            #1;
            s  = c / 8;
            ph = c % 8;
            bl = ph < 2 || lzb[s];
            exp_an  = bl ? 4'hF : ~(4'b1 << s);
            exp_cat = bl ? 8'hFF : cat_tab(e[4*s +: 4]) & ~({7'd0, bus.dp_en[s]} << 7);
            chk($sformatf("f%0d c%0d an", fr, c), {4'd0, bus.seg_an}, {4'd0, exp_an});
            chk($sformatf("f%0d c%0d cat", fr, c), bus.seg_cat, exp_cat);
            chk($sformatf("f%0d c%0d one_an", fr, c), {7'd0, $countones(~bus.seg_an) <= 1}, 8'd1);
        end
        fr++;
    endtask

    initial begin
        set_d(16'h0000);
        bus.dp_en = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst an", {4'd0, bus.seg_an}, 8'h0F);
            chk("rst cat", bus.seg_cat, 8'hFF);
        end
        rst = 1'b0;
        set_d(16'h4321);
        run_frame(16'h0000, 32, -1, 4'd0);
        run_frame(16'h4321, 32, -1, 4'd0);
        run_frame(16'h4321, 32, 4, 4'd7);
        bus.digit2 = 4'hC;
        bus.dp_en  = 4'b0100;
        run_frame(16'h4327, 32, -1, 4'd0);
        run_frame(16'h43C7, 32, -1, 4'd0);
        run_frame(16'h43C7, 21, -1, 4'd0);
        chk("pre_rst an", {4'd0, bus.seg_an}, 8'h0B);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("pulse an", {4'd0, bus.seg_an}, 8'h0F);
        chk("pulse cat", bus.seg_cat, 8'hFF);
        rst = 1'b0;
        bus.dp_en = 4'b0000;
        set_d(16'h0005);
        run_frame(16'h0000, 32, -1, 4'd0);
        set_d(16'h0305);
        run_frame(16'h0005, 32, -1, 4'd0);
        set_d(16'h0070);
        run_frame(16'h0305, 32, -1, 4'd0);
        run_frame(16'h0070, 32, -1, 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
